// File: rtl/real_clock_hms.sv
// Real-time clock core: prescales clk to a 1 Hz tick and keeps hh:mm:ss in 24h or 12h AM/PM form,
// with run/pause, a range-checked time load and a sticky alarm flag.
module real_clock_hms #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter bit MODE_24H    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       set_valid,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       set_pm,
    input  logic       alarm_wr,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_pm,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [5:0] seconds_out,
    output logic [5:0] minutes_out,
    output logic [4:0] hours_out,
    output logic       pm_out,
    output logic       sec_tick,
    output logic       set_err,
    output logic       alarm_flag
);
    localparam int            PW       = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] TC       = PW'(CLK_FREQ_HZ - 1);
    localparam logic [4:0]    HOUR_RST = MODE_24H ? 5'd0 : 5'd12;

    logic [PW-1:0] prescaler;
    logic [4:0]    alarm_h_q;
    logic [5:0]    alarm_m_q;
    logic          alarm_pm_q;

    logic          tick_due;
    logic          set_ok;
    logic          load_ok;
    logic          alarm_hit;
    logic [5:0]    sec_nx;
    logic [5:0]    min_nx;
    logic [4:0]    hrs_nx;
    logic          pm_nx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sec_nx = seconds_out;
        min_nx = minutes_out;
        hrs_nx = hours_out;
        pm_nx  = pm_out;

        tick_due = run && (prescaler == TC);
        set_ok   = (set_seconds <= 6'd59) && (set_minutes <= 6'd59) &&
                   (MODE_24H ? (set_hours <= 5'd23)
                             : (set_hours >= 5'd1 && set_hours <= 5'd12));
        load_ok  = set_valid && set_ok;

        if (seconds_out == 6'd59) begin
            sec_nx = 6'd0;
            if (minutes_out == 6'd59) begin
                min_nx = 6'd0;
                if (MODE_24H) begin
                    hrs_nx = (hours_out == 5'd23) ? 5'd0 : hours_out + 5'd1;
                end else if (hours_out == 5'd11) begin
                    // 11:59:59 -> 12:00:00 is the AM/PM boundary; 12 -> 1 is not.
                    hrs_nx = 5'd12;
                    pm_nx  = ~pm_out;
                end else if (hours_out == 5'd12) begin
                    hrs_nx = 5'd1;
                end else begin
                    hrs_nx = hours_out + 5'd1;
                end
            end else begin
                min_nx = minutes_out + 6'd1;
            end
        end else begin
            sec_nx = seconds_out + 6'd1;
        end

        alarm_hit = tick_due && !load_ok && alarm_en &&
                    (sec_nx == 6'd0) && (min_nx == alarm_m_q) && (hrs_nx == alarm_h_q) &&
                    (MODE_24H || (pm_nx == alarm_pm_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler   <= '0;
            seconds_out <= 6'd0;
            minutes_out <= 6'd0;
            hours_out   <= HOUR_RST;
            pm_out      <= 1'b0;
            sec_tick    <= 1'b0;
            set_err     <= 1'b0;
            alarm_flag  <= 1'b0;
            alarm_h_q   <= HOUR_RST;
            alarm_m_q   <= 6'd0;
            alarm_pm_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sec_tick <= 1'b0;
            set_err  <= 1'b0;

            if (alarm_wr) begin
                alarm_h_q  <= alarm_hours;
                alarm_m_q  <= alarm_minutes;
                alarm_pm_q <= MODE_24H ? 1'b0 : alarm_pm;
            end

            // A match on the same edge as an ack wins, so the event is never lost.
            alarm_flag <= alarm_hit | (alarm_flag & ~alarm_ack);

            if (load_ok) begin
                seconds_out <= set_seconds;
                minutes_out <= set_minutes;
                hours_out   <= set_hours;
                pm_out      <= MODE_24H ? 1'b0 : set_pm;
                prescaler   <= '0;
            end else begin
                set_err <= set_valid;
                if (run) begin
                    prescaler <= tick_due ? '0 : prescaler + 1'b1;
                end
                if (tick_due) begin
                    seconds_out <= sec_nx;
                    minutes_out <= min_nx;
                    hours_out   <= hrs_nx;
                    pm_out      <= MODE_24H ? 1'b0 : pm_nx;
                    sec_tick    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/real_clock_hms.md
# real_clock_hms

Parametrised real-time clock core: divides the system clock down to a 1 Hz tick and keeps seconds, minutes and hours, in either 24-hour or 12-hour AM/PM mode. It extends the earlier seconds/minutes clock with an hours counter, run/pause, a synchronous time-load port with range checking, and a programmable alarm with a sticky flag. It sits directly behind the board clock and drives the display/readout logic.

## Interface
- CLK_FREQ_HZ, 100000000, clk cycles per second; prescaler terminal count = CLK_FREQ_HZ-1 (must be ≥2; benches use 10).
- MODE_24H, 1, 1 = hours 0..23, pm_out tied 0; 0 = hours 1..12 with pm_out.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; returns every register to its reset value.
- run  in  1  1 = prescaler counts; 0 = prescaler and time frozen (not cleared).
- set_valid  in  1  load set_* into the time registers this cycle.
- set_hours  in  5  hours to load.
- set_minutes  in  6  minutes to load.
- set_seconds  in  6  seconds to load.
- set_pm  in  1  PM flag to load (ignored when MODE_24H=1).
- alarm_wr  in  1  capture alarm_hours/alarm_minutes/alarm_pm into the alarm register.
- alarm_hours  in  5  alarm hour.
- alarm_minutes  in  6  alarm minute.
- alarm_pm  in  1  alarm PM flag (ignored when MODE_24H=1).
- alarm_en  in  1  level enable for alarm matching.
- alarm_ack  in  1  clears alarm_flag.
- seconds_out  out  6  0..59.
- minutes_out  out  6  0..59.
- hours_out  out  5  0..23 (24h) or 1..12 (12h).
- pm_out  out  1  PM indicator, 12h mode only.
- sec_tick  out  1  one-cycle pulse coincident with every tick-driven time advance.
- set_err  out  1  one-cycle pulse when a set_valid load is rejected.
- alarm_flag  out  1  sticky alarm indication.

## Operation
- All outputs registered. Reset values: seconds/minutes 0; hours 0 (24h) or 12 (12h); pm_out 0; sec_tick, set_err, alarm_flag 0; prescaler 0; alarm register = midnight (0:00 / 12:00 AM).
- Prescaler width $clog2(CLK_FREQ_HZ). When run=1 it counts 0..CLK_FREQ_HZ-1 and wraps; the wrap is the tick.
- On a tick: seconds+1; 59→0 carries into minutes; minutes 59→0 carries into hours.
- 24h: hours 23→0. 12h: 11→12 toggles pm_out; 12→1 keeps pm_out; sequence 12,1..11.
- Priority per edge: reset > set_valid > tick > hold.
- set_valid: range check (seconds/minutes ≤59; hours ≤23 in 24h, 1..12 in 12h). Valid: time loads, prescaler cleared to 0, no sec_tick, no alarm evaluation. Invalid: time and prescaler unchanged (tick still processed if due), set_err=1 for one cycle.
- alarm_wr: alarm register updated unconditionally (out-of-range alarm simply never matches). Independent of set_valid/tick.
- Alarm match: only on tick-driven advances, when the new time equals alarm hh:mm:00 (and pm in 12h) and alarm_en=1. Loads never fire the alarm.
- alarm_flag: set by a match, cleared by alarm_ack; match and ack on the same edge → flag stays 1.

## Timing
- After reset release with run held 1, first tick edge is the CLK_FREQ_HZ-th rising edge; the next tick follows every CLK_FREQ_HZ edges.
- Tick edge: prescaler→0, new time visible, sec_tick=1, alarm_flag=1 if matched — all on the same edge (zero extra latency).
- set_valid sampled at edge N → loaded values visible after edge N; first subsequent tick CLK_FREQ_HZ edges later. set_valid at terminal count: load wins, tick discarded.
- run=0 for K cycles delays all later ticks by exactly K cycles.
- Reset mid-count: all outputs at reset values after that edge, regardless of other inputs.

## Test plan
- CLK_FREQ_HZ=10, reset then run=1 → 00:00:00, sec_tick first high on 10th edge with seconds_out=1, period 10 cycles.
- 24h: load 23:59:58 → two ticks later 00:00:00; load 00:59:59 → next tick 01:00:00.
- MODE_24H=0: load 11:59:59 AM → 12:00:00 pm_out=1; load 12:59:59 PM → 01:00:00 pm_out=1; reset → 12:00:00 pm_out=0.
- Alarm 07:30 en=1, load 07:29:59 → next tick 07:30:00 with alarm_flag=1 same edge; holds until alarm_ack; ack coincident with match keeps 1; loading 07:30:00 directly does not fire; alarm_en=0 does not fire.
- Load minutes=60 → set_err pulse, time unchanged; valid load on terminal-count cycle → loaded value, no sec_tick.
- run=0 for 25 cycles mid-second → tick delayed by exactly 25 cycles; reset asserted mid-count → all outputs reset next edge.
